sobel_window_sequencer: RTL and testbench

Synthesizable host-side initiator for the stochastic Sobel core. It scans a source image held in a synchronous-read memory in raster order and builds each 3x3 neighbourhood. It launches the core with the existing start/done handshake and writes each binary result into a densely packed edge memory. The block replaces the software window loop so the core can run from on-chip image buffers.

---
 rtl/sobel_window_sequencer_if.sv | 44 ++++
 rtl/sobel_window_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_sobel_window_sequencer.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_window_sequencer_if.sv
// Bus bundle between the Sobel window sequencer and its environment.
//   go/busy/finished/err : host control and status
//   src_*                : synchronous-read source image memory port
//   pixel_*_bin          : eight neighbourhood pixels to the core (centre omitted)
//   core_start/done/z    : existing core launch handshake and result
//   edge_*               : edge-image memory write port
// master = the sequencer, slave = host / memories / core.
interface sobel_window_sequencer_if #(
  parameter int PIX_W       = 8,
  parameter int ADDR_W      = 16,
  parameter int EDGE_ADDR_W = 16
);
  logic                   go;
  logic                   busy;
  logic                   finished;
  logic                   err;
  logic                   src_rd_en;
  logic [ADDR_W-1:0]      src_addr;
  logic [PIX_W-1:0]       src_rdata;
  logic [PIX_W-1:0]       pixel_1_bin, pixel_2_bin, pixel_3_bin, pixel_4_bin;
  logic [PIX_W-1:0]       pixel_6_bin, pixel_7_bin, pixel_8_bin, pixel_9_bin;
  logic                   core_start;
  logic                   core_done;
  logic [PIX_W-1:0]       core_z;
  logic                   edge_we;
  logic [EDGE_ADDR_W-1:0] edge_addr;
  logic [PIX_W-1:0]       edge_wdata;

  modport master (
    input  go, src_rdata, core_done, core_z,
    output busy, finished, err, src_rd_en, src_addr,
           pixel_1_bin, pixel_2_bin, pixel_3_bin, pixel_4_bin,
           pixel_6_bin, pixel_7_bin, pixel_8_bin, pixel_9_bin,
           core_start, edge_we, edge_addr, edge_wdata
  );

  modport slave (
    output go, src_rdata, core_done, core_z,
    input  busy, finished, err, src_rd_en, src_addr,
           pixel_1_bin, pixel_2_bin, pixel_3_bin, pixel_4_bin,
           pixel_6_bin, pixel_7_bin, pixel_8_bin, pixel_9_bin,
           core_start, edge_we, edge_addr, edge_wdata
  );
endinterface

// File: rtl/sobel_window_sequencer.sv
// Scans a source image in raster order, fetches each interior 3x3
// neighbourhood (centre excluded), launches the Sobel core and writes its
// binary result into a densely packed edge memory.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : sobel_window_sequencer_if.master (control, source read port,
//           core handshake, edge write port)
module sobel_window_sequencer #(
  parameter int SRC_ROWS    = 3,
  parameter int SRC_COLS    = 3,
  parameter int PIX_W       = 8,
  parameter int ADDR_W      = 16,
  parameter int EDGE_ADDR_W = 16,
  parameter int TIMEOUT     = 1024
) (
  input logic                      clk,
  input logic                      reset,
  sobel_window_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LAUNCH, S_WAIT, S_WRITE, S_FINISH
  } state_t;

  localparam int RC_W = 16;
  localparam int TO_W = $clog2(TIMEOUT + 1);

  state_t             state_q;
  logic [RC_W-1:0]    row_q, col_q;
  logic [3:0]         fcnt_q;
  logic [TO_W-1:0]    wcnt_q;
  logic               done_prev_q;
  logic               busy_q, finished_q, err_q, rd_en_q, core_start_q, we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [EDGE_ADDR_W-1:0] eaddr_q;
  logic [PIX_W-1:0]   wdata_q;
  logic [PIX_W-1:0]   pix_q [8];

  logic               done_edge, last_col, last_row;
  logic [RC_W-1:0]    nxt_row, nxt_col;
  logic [EDGE_ADDR_W-1:0] cur_eaddr;

  // Source address of tap k (0..7, row-major, centre skipped) around (r, c).
  function automatic logic [ADDR_W-1:0] tap_addr(input logic [RC_W-1:0] r,
                                                 input logic [RC_W-1:0] c,
                                                 input logic [2:0]      k);
    int dr, dc;
    case (k)
      3'd0:    begin dr = -1; dc = -1; end
      3'd1:    begin dr = -1; dc =  0; end
      3'd2:    begin dr = -1; dc =  1; end
      3'd3:    begin dr =  0; dc = -1; end
      3'd4:    begin dr =  0; dc =  1; end
      3'd5:    begin dr =  1; dc = -1; end
      3'd6:    begin dr =  1; dc =  0; end
      default: begin dr =  1; dc =  1; end
    endcase
    return ADDR_W'((int'(r) + dr) * SRC_COLS + int'(c) + dc);
  endfunction

  // Only a 0->1 transition of core_done completes a window; a level that is
  // already high when WAIT is entered does not count.
  assign done_edge = bus.core_done & ~done_prev_q;
  assign cur_eaddr = EDGE_ADDR_W'((SRC_COLS - 2) * (int'(row_q) - 1) + int'(col_q) - 1);

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    last_col = (col_q >= RC_W'(SRC_COLS - 2));
    last_row = (row_q >= RC_W'(SRC_ROWS - 2));
    nxt_row  = row_q;
    nxt_col  = col_q;
    if (!last_col) begin
      nxt_col = col_q + RC_W'(1);
    end else if (!last_row) begin
      nxt_col = RC_W'(1);
      nxt_row = row_q + RC_W'(1);
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      row_q        <= RC_W'(1);
      col_q        <= RC_W'(1);
      fcnt_q       <= '0;
      wcnt_q       <= '0;
      done_prev_q  <= 1'b0;
      busy_q       <= 1'b0;
      finished_q   <= 1'b0;
      err_q        <= 1'b0;
      rd_en_q      <= 1'b0;
      core_start_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      eaddr_q      <= '0;
      wdata_q      <= '0;
      // NOTE: the window registers are reset because they drive the core
      // directly and must read as zero after reset.
      for (int i = 0; i < 8; i++) pix_q[i] <= '0;
    end else begin
      done_prev_q <= bus.core_done;
      case (state_q)
        S_IDLE: begin
          if (bus.go) begin
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            row_q   <= RC_W'(1);
            col_q   <= RC_W'(1);
            fcnt_q  <= '0;
            rd_en_q <= 1'b1;
            addr_q  <= tap_addr(RC_W'(1), RC_W'(1), 3'd0);
            state_q <= S_FETCH;
          end
        end
        // fcnt_q 0..7 have a read outstanding; data for read k is captured
        // on fcnt_q == k+1, so the ninth cycle only captures the last tap.
        S_FETCH: begin
          if (fcnt_q != 4'd0) pix_q[3'(fcnt_q - 4'd1)] <= bus.src_rdata;
          if (fcnt_q < 4'd7) begin
            rd_en_q <= 1'b1;
            addr_q  <= tap_addr(row_q, col_q, 3'(fcnt_q + 4'd1));
          end else begin
            rd_en_q <= 1'b0;
          end
          if (fcnt_q == 4'd8) begin
            core_start_q <= 1'b0;
            state_q      <= S_LAUNCH;
          end else begin
            fcnt_q <= fcnt_q + 4'd1;
          end
        end
        S_LAUNCH: begin
          wcnt_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (done_edge) begin
            wdata_q      <= bus.core_z;
            core_start_q <= 1'b1;
            we_q         <= 1'b1;
            eaddr_q      <= cur_eaddr;
            state_q      <= S_WRITE;
          end else if (wcnt_q == TO_W'(TIMEOUT - 1)) begin
            // Abandon the window: write a zero result and flag it.
            wdata_q      <= '0;
            err_q        <= 1'b1;
            core_start_q <= 1'b1;
            we_q         <= 1'b1;
            eaddr_q      <= cur_eaddr;
            state_q      <= S_WRITE;
          end else begin
            wcnt_q <= wcnt_q + TO_W'(1);
          end
        end
        S_WRITE: begin
          we_q <= 1'b0;
          if (last_col && last_row) begin
            finished_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= S_FINISH;
          end else begin
            row_q   <= nxt_row;
            col_q   <= nxt_col;
            fcnt_q  <= '0;
            rd_en_q <= 1'b1;
            addr_q  <= tap_addr(nxt_row, nxt_col, 3'd0);
            state_q <= S_FETCH;
          end
        end
        S_FINISH: begin
          finished_q <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.finished    = finished_q;
  assign bus.err         = err_q;
  assign bus.src_rd_en   = rd_en_q;
  assign bus.src_addr    = addr_q;
  assign bus.core_start  = core_start_q;
  assign bus.edge_we     = we_q;
  assign bus.edge_addr   = eaddr_q;
  assign bus.edge_wdata  = wdata_q;
  assign bus.pixel_1_bin = pix_q[0];
  assign bus.pixel_2_bin = pix_q[1];
  assign bus.pixel_3_bin = pix_q[2];
  assign bus.pixel_4_bin = pix_q[3];
  assign bus.pixel_6_bin = pix_q[4];
  assign bus.pixel_7_bin = pix_q[5];
  assign bus.pixel_8_bin = pix_q[6];
  assign bus.pixel_9_bin = pix_q[7];

endmodule

// File: tb/tb_sobel_window_sequencer.sv
// Bench for sobel_window_sequencer: a 3x3 instance (TIMEOUT 1024) and a 4x5
// instance (TIMEOUT 16), each with a source memory holding mem[i]=i and a
// mock core. Expected reads/writes are queued when go is driven and popped
// as the DUT produces them.
module tb_sobel_window_sequencer;

  localparam int M_NORMAL = 0;
  localparam int M_STUCK  = 1;
  localparam int M_NEVER  = 2;

  typedef struct {
    string name;
    int    d;        // 0 = 3x3 instance, 1 = 4x5 instance
    int    mode;
    int    lat;
    int    fn;       // 0: pixel_1^pixel_9, 1: pixel_2
    int    exp_wr;
    int    exp_err;
    int    exp_low;  // cycles core_start is low in the last window
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sobel_window_sequencer_if bus_s ();
  sobel_window_sequencer_if bus_l ();

  sobel_window_sequencer #(.SRC_ROWS(3), .SRC_COLS(3), .TIMEOUT(1024)) dut_s (
    .clk(clk), .reset(rst_n), .bus(bus_s));
  sobel_window_sequencer #(.SRC_ROWS(4), .SRC_COLS(5), .TIMEOUT(16)) dut_l (
    .clk(clk), .reset(rst_n), .bus(bus_l));

  logic [7:0] mem_s [9];
  logic [7:0] mem_l [20];
  logic       go_s = 1'b0, go_l = 1'b0;
  logic       done_s = 1'b0, done_l = 1'b0;
  logic [7:0] z_s = '0, z_l = '0, rd_s = '0, rd_l = '0;
  int         mode_s = M_NORMAL, mode_l = M_NORMAL;
  int         lat_s = 20, lat_l = 5, fn_s = 0, fn_l = 1;
  int         cnt_s = 0, cnt_l = 0;

  assign bus_s.go = go_s;  assign bus_s.core_done = done_s;
  assign bus_s.core_z = z_s; assign bus_s.src_rdata = rd_s;
  assign bus_l.go = go_l;  assign bus_l.core_done = done_l;
  assign bus_l.core_z = z_l; assign bus_l.src_rdata = rd_l;

  int n_cmp = 0, n_fail = 0;
  int exp_rd_s[$], exp_wa_s[$], exp_wd_s[$];
  int exp_rd_l[$], exp_wa_l[$], exp_wd_l[$];
  int wr_cnt_s = 0, wr_cnt_l = 0, fin_cnt_s = 0, fin_cnt_l = 0;
  int cur_low_s = 0, cur_low_l = 0, last_low_s = 0, last_low_l = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Source memories: synchronous read, data one cycle after the strobe.
  always @(posedge clk) if (bus_s.src_rd_en) rd_s <= mem_s[bus_s.src_addr];
  always @(posedge clk) if (bus_l.src_rd_en) rd_l <= mem_l[bus_l.src_addr];

  // Mock cores: done rises lat cycles after core_start falls (counting the
  // launch cycle) and clears once core_start returns high, except in STUCK
  // mode where it never clears; NEVER mode never raises it.
  always @(posedge clk) begin
    if (bus_s.core_start) begin
      cnt_s <= 0;
      if (mode_s != M_STUCK) done_s <= 1'b0;
    end else begin
      cnt_s <= cnt_s + 1;
      if (cnt_s == lat_s - 1 && mode_s != M_NEVER) begin
        done_s <= 1'b1;
        z_s    <= (fn_s == 1) ? bus_s.pixel_2_bin : (bus_s.pixel_1_bin ^ bus_s.pixel_9_bin);
      end
    end
  end

  always @(posedge clk) begin
    if (bus_l.core_start) begin
      cnt_l <= 0;
      if (mode_l != M_STUCK) done_l <= 1'b0;
    end else begin
      cnt_l <= cnt_l + 1;
      if (cnt_l == lat_l - 1 && mode_l != M_NEVER) begin
        done_l <= 1'b1;
        z_l    <= (fn_l == 1) ? bus_l.pixel_2_bin : (bus_l.pixel_1_bin ^ bus_l.pixel_9_bin);
      end
    end
  end

  // Output monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus_s.src_rd_en) begin
      check("s_rd_expected", int'(exp_rd_s.size() > 0), 1);
      if (exp_rd_s.size() > 0) check("s_rd_addr", bus_s.src_addr, exp_rd_s.pop_front());
    end
    if (bus_s.edge_we) begin
      wr_cnt_s <= wr_cnt_s + 1;
      check("s_wr_expected", int'(exp_wa_s.size() > 0), 1);
      if (exp_wa_s.size() > 0) begin
        check("s_wr_addr", bus_s.edge_addr, exp_wa_s.pop_front());
        check("s_wr_data", bus_s.edge_wdata, exp_wd_s.pop_front());
      end
    end
    if (bus_s.finished) fin_cnt_s <= fin_cnt_s + 1;
    if (!bus_s.core_start) cur_low_s <= cur_low_s + 1;
    else if (cur_low_s != 0) begin last_low_s <= cur_low_s; cur_low_s <= 0; end
  end

  always @(negedge clk) begin
    if (bus_l.src_rd_en) begin
      check("l_rd_expected", int'(exp_rd_l.size() > 0), 1);
      if (exp_rd_l.size() > 0) check("l_rd_addr", bus_l.src_addr, exp_rd_l.pop_front());
    end
    if (bus_l.edge_we) begin
      wr_cnt_l <= wr_cnt_l + 1;
      check("l_wr_expected", int'(exp_wa_l.size() > 0), 1);
      if (exp_wa_l.size() > 0) begin
        check("l_wr_addr", bus_l.edge_addr, exp_wa_l.pop_front());
        check("l_wr_data", bus_l.edge_wdata, exp_wd_l.pop_front());
      end
    end
    if (bus_l.finished) fin_cnt_l <= fin_cnt_l + 1;
    if (!bus_l.core_start) cur_low_l <= cur_low_l + 1;
    else if (cur_low_l != 0) begin last_low_l <= cur_low_l; cur_low_l <= 0; end
  end

  function automatic int mval(input int d, input int a);
    return (d == 0) ? int'(mem_s[a]) : int'(mem_l[a]);
  endfunction

  // Reference model: queue every read and write of one full image pass.
  task automatic push_run(input int d, input int mode, input int fn, input bit with_wr);
    int dr[8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    int dc[8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    int rows = (d == 0) ? 3 : 4;
    int cols = (d == 0) ? 3 : 5;
    int w = 0;
    for (int r = 1; r <= rows - 2; r++) begin
      for (int c = 1; c <= cols - 2; c++) begin
        int z, ea;
        for (int k = 0; k < 8; k++) begin
          if (d == 0) exp_rd_s.push_back((r + dr[k]) * cols + c + dc[k]);
          else        exp_rd_l.push_back((r + dr[k]) * cols + c + dc[k]);
        end
        z = (fn == 1) ? mval(d, (r - 1) * cols + c)
                      : (mval(d, (r - 1) * cols + c - 1) ^ mval(d, (r + 1) * cols + c + 1));
        if (mode == M_NEVER || (mode == M_STUCK && w > 0)) z = 0;
        ea = (cols - 2) * (r - 1) + c - 1;
        if (with_wr) begin
          if (d == 0) begin exp_wa_s.push_back(ea); exp_wd_s.push_back(z); end
          else        begin exp_wa_l.push_back(ea); exp_wd_l.push_back(z); end
        end
        w++;
      end
    end
  endtask

  task automatic pulse_go(input int d);
    @(negedge clk);
    if (d == 0) go_s = 1'b1; else go_l = 1'b1;
    @(negedge clk);
    if (d == 0) go_s = 1'b0; else go_l = 1'b0;
  endtask

  task automatic wait_fin(input int d, input int base, input string name);
    int seen = 0;
    for (int i = 0; i < 5000 && seen == 0; i++) begin
      @(posedge clk);
      if (((d == 0) ? fin_cnt_s : fin_cnt_l) > base) seen = 1;
    end
    check({name, "_finished_seen"}, seen, 1);
  endtask

  task automatic set_core(input int d, input int mode, input int lat, input int fn);
    @(negedge clk);
    if (d == 0) begin mode_s = mode; lat_s = lat; fn_s = fn; end
    else        begin mode_l = mode; lat_l = lat; fn_l = fn; end
    repeat (2) @(negedge clk);
  endtask

  vec_t tbl[4];

  initial begin
    int wb, fb;
    for (int i = 0; i < 9; i++)  mem_s[i] = 8'(i);
    for (int i = 0; i < 20; i++) mem_l[i] = 8'(i);

    tbl[0] = '{"t1_3x3",   0, M_NORMAL, 20, 0, 1, 0, 21};
    tbl[1] = '{"t2_4x5",   1, M_NORMAL, 5,  1, 6, 0, 6};
    tbl[2] = '{"t3_stuck", 1, M_STUCK,  5,  1, 6, 1, 17};
    tbl[3] = '{"t4_never", 1, M_NEVER,  5,  1, 6, 1, 17};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_busy", bus_s.busy, 0);
    check("rst_core_start", bus_s.core_start, 1);
    check("rst_edge_we", bus_s.edge_we, 0);
    check("rst_src_rd_en", bus_s.src_rd_en, 0);
    check("rst_err", bus_l.err, 0);
    check("rst_pixel_9", bus_l.pixel_9_bin, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven full-image runs.
    for (int i = 0; i < 4; i++) begin
      set_core(tbl[i].d, tbl[i].mode, tbl[i].lat, tbl[i].fn);
      push_run(tbl[i].d, tbl[i].mode, tbl[i].fn, 1'b1);
      wb = (tbl[i].d == 0) ? wr_cnt_s : wr_cnt_l;
      fb = (tbl[i].d == 0) ? fin_cnt_s : fin_cnt_l;
      pulse_go(tbl[i].d);
      wait_fin(tbl[i].d, fb, tbl[i].name);
      repeat (4) @(negedge clk);
      if (tbl[i].d == 0) begin
        check({tbl[i].name, "_writes"}, wr_cnt_s - wb, tbl[i].exp_wr);
        check({tbl[i].name, "_finished"}, fin_cnt_s - fb, 1);
        check({tbl[i].name, "_err"}, bus_s.err, tbl[i].exp_err);
        check({tbl[i].name, "_busy"}, bus_s.busy, 0);
        check({tbl[i].name, "_start_low"}, last_low_s, tbl[i].exp_low);
        check({tbl[i].name, "_queue"}, exp_rd_s.size() + exp_wa_s.size(), 0);
      end else begin
        check({tbl[i].name, "_writes"}, wr_cnt_l - wb, tbl[i].exp_wr);
        check({tbl[i].name, "_finished"}, fin_cnt_l - fb, 1);
        check({tbl[i].name, "_err"}, bus_l.err, tbl[i].exp_err);
        check({tbl[i].name, "_busy"}, bus_l.busy, 0);
        check({tbl[i].name, "_start_low"}, last_low_l, tbl[i].exp_low);
        check({tbl[i].name, "_queue"}, exp_rd_l.size() + exp_wa_l.size(), 0);
      end
    end

    // Window registers of the single 3x3 window remain on the core port.
    check("t1_pixel_1", bus_s.pixel_1_bin, mem_s[0]);
    check("t1_pixel_9", bus_s.pixel_9_bin, mem_s[8]);

    // Sticky err survives idle and is cleared by the next accepted go.
    check("t4_err_sticky", bus_l.err, 1);
    set_core(1, M_NORMAL, 5, 1);
    push_run(1, M_NORMAL, 1, 1'b1);
    fb = fin_cnt_l;
    pulse_go(1);
    check("t4_err_cleared", bus_l.err, 0);
    check("t4_busy_set", bus_l.busy, 1);
    wait_fin(1, fb, "t4_rerun");
    repeat (3) @(negedge clk);
    check("t4_rerun_err", bus_l.err, 0);

    // Asynchronous reset while waiting on the core.
    set_core(0, M_NEVER, 20, 0);
    push_run(0, M_NEVER, 0, 1'b0);
    pulse_go(0);
    begin
      int seen = 0;
      for (int i = 0; i < 100 && seen == 0; i++) begin
        @(negedge clk);
        if (!bus_s.core_start) seen = 1;
      end
      check("t5_launch_seen", seen, 1);
    end
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_core_start", bus_s.core_start, 1);
    check("t5_busy", bus_s.busy, 0);
    check("t5_edge_we", bus_s.edge_we, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("t5_reads_done", exp_rd_s.size(), 0);
    set_core(0, M_NORMAL, 20, 0);
    push_run(0, M_NORMAL, 0, 1'b1);
    wb = wr_cnt_s; fb = fin_cnt_s;
    pulse_go(0);
    wait_fin(0, fb, "t5_restart");
    repeat (3) @(negedge clk);
    check("t5_restart_writes", wr_cnt_s - wb, 1);

    // go while busy is ignored.
    push_run(0, M_NORMAL, 0, 1'b1);
    wb = wr_cnt_s; fb = fin_cnt_s;
    pulse_go(0);
    repeat (3) @(negedge clk);
    pulse_go(0);
    repeat (18) @(negedge clk);
    pulse_go(0);
    wait_fin(0, fb, "t6_busy_go");
    repeat (50) @(negedge clk);
    check("t6_writes", wr_cnt_s - wb, 1);
    check("t6_finished", fin_cnt_s - fb, 1);
    check("t6_queue", exp_rd_s.size() + exp_wa_s.size(), 0);
    check("t6_busy", bus_s.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
